// File: rtl/ascon_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between ascon_ctrl_fsm and its neighbours.
// abort_i is present only when ASCON_CTRL_ABORT_EN is defined.
interface ascon_ctrl_fsm_if;
    logic       start_i;
    logic       data_valid_i;
`ifdef ASCON_CTRL_ABORT_EN
    logic       abort_i;
`endif
    logic [3:0] round_o;
    logic       input_select_o;
    logic       ena_xor_up_o;
    logic       xor_up_key_o;
    logic       ena_xor_down_o;
    logic [1:0] xor_down_sel_o;
    logic       ena_reg_state_o;
    logic       ena_cipher_o;
    logic       ena_tag_o;
    logic       data_ack_o;
    logic [3:0] block_idx_o;
    logic       busy_o;
    logic       done_o;

    modport master (
`ifdef ASCON_CTRL_ABORT_EN
        input  abort_i,
`endif
        input  start_i,
        input  data_valid_i,
        output round_o,
        output input_select_o,
        output ena_xor_up_o,
        output xor_up_key_o,
        output ena_xor_down_o,
        output xor_down_sel_o,
        output ena_reg_state_o,
        output ena_cipher_o,
        output ena_tag_o,
        output data_ack_o,
        output block_idx_o,
        output busy_o,
        output done_o
    );

    modport slave (
`ifdef ASCON_CTRL_ABORT_EN
        output abort_i,
`endif
        output start_i,
        output data_valid_i,
        input  round_o,
        input  input_select_o,
        input  ena_xor_up_o,
        input  xor_up_key_o,
        input  ena_xor_down_o,
        input  xor_down_sel_o,
        input  ena_reg_state_o,
        input  ena_cipher_o,
        input  ena_tag_o,
        input  data_ack_o,
        input  block_idx_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: INIT (p^a), one AD block, PT_BLOCKS plaintext blocks, FINAL (p^a), TAG.
// Optional ASCON_CTRL_ABORT_EN adds abort_i, which returns the controller to IDLE from any busy state.
module ascon_ctrl_fsm #(
    parameter int unsigned PT_BLOCKS = 4
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    ascon_ctrl_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_WAIT_AD = 3'd2,
        S_AD      = 3'd3,
        S_WAIT_PT = 3'd4,
        S_PT      = 3'd5,
        S_FINAL   = 3'd6,
        S_TAG     = 3'd7
    } state_t;

    typedef struct packed {
        logic [3:0] round;
        logic       input_select;
        logic       ena_xor_up;
        logic       xor_up_key;
        logic       ena_xor_down;
        logic [1:0] xor_down_sel;
        logic       ena_reg_state;
        logic       ena_cipher;
        logic       ena_tag;
        logic       data_ack;
        logic [3:0] block_idx;
        logic       busy;
        logic       done;
    } ctrl_t;

    localparam ctrl_t      CTRL_ZERO = ctrl_t'(20'h0_0000);
    localparam logic [3:0] RND_LAST  = 4'hB;
    localparam logic [3:0] RND_PB    = 4'd6;
    localparam logic [3:0] LAST_BLK  = 4'(PT_BLOCKS - 1);

    state_t     state_r;
    state_t     state_nx_s;
    logic [3:0] rnd_r;
    logic [3:0] rnd_nx_s;
    logic [3:0] blk_r;
    logic [3:0] blk_nx_s;
    ctrl_t      out_r;
    ctrl_t      out_nx_s;
    logic       last_rnd_s;
    logic       abort_s;

    assign last_rnd_s = (rnd_r == RND_LAST);

`ifdef ASCON_CTRL_ABORT_EN
    assign abort_s = bus.abort_i;
`else
    assign abort_s = 1'b0;
`endif

    // State, counters and the output register; outputs are decoded one cycle ahead so they stay Moore-aligned.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_r <= S_IDLE;
            rnd_r   <= 4'd0;
            blk_r   <= 4'd0;
            out_r   <= CTRL_ZERO;
        end else begin
            state_r <= state_nx_s;
            rnd_r   <= rnd_nx_s;
            blk_r   <= blk_nx_s;
            out_r   <= out_nx_s;
        end
    end

    // Next-state, round-counter and block-counter logic.
    always_comb begin
        state_nx_s = state_r;
        rnd_nx_s   = rnd_r;
        blk_nx_s   = blk_r;
        if (abort_s && (state_r != S_IDLE)) begin
            state_nx_s = S_IDLE;
            rnd_nx_s   = 4'd0;
            blk_nx_s   = 4'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_nx_s = S_INIT;
                        rnd_nx_s   = 4'd0;
                        blk_nx_s   = 4'd0;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_INIT: begin
                    if (last_rnd_s) begin
                        state_nx_s = S_WAIT_AD;
                        rnd_nx_s   = 4'd0;
                    end else begin
                        rnd_nx_s   = rnd_r + 4'd1;
                    end
                end
                S_WAIT_AD: begin
                    if (bus.data_valid_i) begin
                        state_nx_s = S_AD;
                        rnd_nx_s   = RND_PB;
                    end else begin
                        state_nx_s = S_WAIT_AD;
                    end
                end
                S_AD: begin
                    if (last_rnd_s) begin
                        state_nx_s = S_WAIT_PT;
                        rnd_nx_s   = 4'd0;
                    end else begin
                        rnd_nx_s   = rnd_r + 4'd1;
                    end
                end
                S_WAIT_PT: begin
                    // The last plaintext block is absorbed by FINAL together with the key XOR.
                    if (bus.data_valid_i) begin
                        if (blk_r == LAST_BLK) begin
                            state_nx_s = S_FINAL;
                            rnd_nx_s   = 4'd0;
                        end else begin
                            state_nx_s = S_PT;
                            rnd_nx_s   = RND_PB;
                        end
                    end else begin
                        state_nx_s = S_WAIT_PT;
                    end
                end
                S_PT: begin
                    if (last_rnd_s) begin
                        state_nx_s = S_WAIT_PT;
                        rnd_nx_s   = 4'd0;
                        blk_nx_s   = blk_r + 4'd1;
                    end else begin
                        rnd_nx_s   = rnd_r + 4'd1;
                    end
                end
                S_FINAL: begin
                    if (last_rnd_s) begin
                        state_nx_s = S_TAG;
                        rnd_nx_s   = 4'd0;
                    end else begin
                        rnd_nx_s   = rnd_r + 4'd1;
                    end
                end
                S_TAG: begin
                    state_nx_s = S_IDLE;
                    rnd_nx_s   = 4'd0;
                    blk_nx_s   = 4'd0;
                end
                default: begin
                    state_nx_s = S_IDLE;
                    rnd_nx_s   = 4'd0;
                    blk_nx_s   = 4'd0;
                end
            endcase
        end
    end

    // Output decode of the upcoming state/round/block values.
    always_comb begin
        out_nx_s = CTRL_ZERO;
        case (state_nx_s)
            S_IDLE: begin
                out_nx_s = CTRL_ZERO;
            end
            S_INIT: begin
                out_nx_s.round         = rnd_nx_s;
                out_nx_s.ena_reg_state = 1'b1;
                out_nx_s.input_select  = (rnd_nx_s == 4'd0);
                out_nx_s.ena_xor_down  = (rnd_nx_s == RND_LAST);
                out_nx_s.xor_down_sel  = 2'b00;
            end
            S_WAIT_AD, S_WAIT_PT: begin
                out_nx_s.ena_reg_state = 1'b0;
            end
            S_AD: begin
                out_nx_s.round         = rnd_nx_s;
                out_nx_s.ena_reg_state = 1'b1;
                out_nx_s.ena_xor_up    = (rnd_nx_s == RND_PB);
                out_nx_s.data_ack      = (rnd_nx_s == RND_PB);
                out_nx_s.ena_xor_down  = (rnd_nx_s == RND_LAST);
                out_nx_s.xor_down_sel  = {1'b0, (rnd_nx_s == RND_LAST)};
            end
            S_PT: begin
                out_nx_s.round         = rnd_nx_s;
                out_nx_s.ena_reg_state = 1'b1;
                out_nx_s.ena_xor_up    = (rnd_nx_s == RND_PB);
                out_nx_s.ena_cipher    = (rnd_nx_s == RND_PB);
                out_nx_s.data_ack      = (rnd_nx_s == RND_PB);
            end
            S_FINAL: begin
                out_nx_s.round         = rnd_nx_s;
                out_nx_s.ena_reg_state = 1'b1;
                out_nx_s.ena_xor_up    = (rnd_nx_s == 4'd0);
                out_nx_s.xor_up_key    = (rnd_nx_s == 4'd0);
                out_nx_s.ena_cipher    = (rnd_nx_s == 4'd0);
                out_nx_s.data_ack      = (rnd_nx_s == 4'd0);
                out_nx_s.ena_xor_down  = (rnd_nx_s == RND_LAST);
                out_nx_s.xor_down_sel  = {(rnd_nx_s == RND_LAST), 1'b0};
            end
            S_TAG: begin
                out_nx_s.ena_tag       = 1'b1;
                out_nx_s.done          = 1'b1;
            end
            default: begin
                out_nx_s = CTRL_ZERO;
            end
        endcase
        out_nx_s.busy      = (state_nx_s != S_IDLE);
        out_nx_s.block_idx = (state_nx_s != S_IDLE) ? blk_nx_s : 4'd0;
    end

    assign bus.round_o         = out_r.round;
    assign bus.input_select_o  = out_r.input_select;
    assign bus.ena_xor_up_o    = out_r.ena_xor_up;
    assign bus.xor_up_key_o    = out_r.xor_up_key;
    assign bus.ena_xor_down_o  = out_r.ena_xor_down;
    assign bus.xor_down_sel_o  = out_r.xor_down_sel;
    assign bus.ena_reg_state_o = out_r.ena_reg_state;
    assign bus.ena_cipher_o    = out_r.ena_cipher;
    assign bus.ena_tag_o       = out_r.ena_tag;
    assign bus.data_ack_o      = out_r.data_ack;
    assign bus.block_idx_o     = out_r.block_idx;
    assign bus.busy_o          = out_r.busy;
    assign bus.done_o          = out_r.done;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Scoreboard bench for ascon_ctrl_fsm: per-cycle expected control vectors built from the message timeline.
// Instantiates PT_BLOCKS=4 and PT_BLOCKS=1 controllers; abort cases run when ASCON_CTRL_ABORT_EN is defined.
module tb_ascon_ctrl_fsm;

    logic clock_i = 1'b0;
    logic resetb_i;

    always #5 clock_i = ~clock_i;

    ascon_ctrl_fsm_if bus4 ();
    ascon_ctrl_fsm_if bus1 ();

    ascon_ctrl_fsm #(.PT_BLOCKS(4)) dut4 (.clock_i(clock_i), .resetb_i(resetb_i), .bus(bus4));
    ascon_ctrl_fsm #(.PT_BLOCKS(1)) dut1 (.clock_i(clock_i), .resetb_i(resetb_i), .bus(bus1));

    typedef struct {
        logic        st;
        logic        dv;
        logic        ab;
        logic [19:0] out;
    } plan_t;

    plan_t       plan_q[$];
    logic [19:0] sb_q[$];
    int          n_checks;
    int          n_fail;
    int          sel;
    int          start_idx;
    int          done_cyc;
    int          done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] exp_out(input int rnd, input logic insel, input logic xu,
                                            input logic xuk, input logic xd, input logic [1:0] xds,
                                            input logic ers, input logic ec, input logic et,
                                            input logic ack, input int bidx, input logic busy,
                                            input logic done);
        return {rnd[3:0], insel, xu, xuk, xd, xds, ers, ec, et, ack, bidx[3:0], busy, done};
    endfunction

    function automatic logic [19:0] obs_vec(input int s);
        if (s == 0)
            return {bus4.round_o, bus4.input_select_o, bus4.ena_xor_up_o, bus4.xor_up_key_o,
                    bus4.ena_xor_down_o, bus4.xor_down_sel_o, bus4.ena_reg_state_o, bus4.ena_cipher_o,
                    bus4.ena_tag_o, bus4.data_ack_o, bus4.block_idx_o, bus4.busy_o, bus4.done_o};
        else
            return {bus1.round_o, bus1.input_select_o, bus1.ena_xor_up_o, bus1.xor_up_key_o,
                    bus1.ena_xor_down_o, bus1.xor_down_sel_o, bus1.ena_reg_state_o, bus1.ena_cipher_o,
                    bus1.ena_tag_o, bus1.data_ack_o, bus1.block_idx_o, bus1.busy_o, bus1.done_o};
    endfunction

    task automatic drive(input plan_t p);
        bus4.start_i      = (sel == 0) ? p.st : 1'b0;
        bus4.data_valid_i = (sel == 0) ? p.dv : 1'b0;
        bus1.start_i      = (sel == 1) ? p.st : 1'b0;
        bus1.data_valid_i = (sel == 1) ? p.dv : 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
        bus4.abort_i      = (sel == 0) ? p.ab : 1'b0;
        bus1.abort_i      = (sel == 1) ? p.ab : 1'b0;
`endif
    endtask

    task automatic put(input logic st, input logic dv, input logic ab, input logic [19:0] out);
        plan_t p;
        p.st = st; p.dv = dv; p.ab = ab; p.out = out;
        plan_q.push_back(p);
    endtask

    task automatic gen_idle(input int n);
        plan_q.delete();
        start_idx = 0;
        for (int k = 0; k < n; k++) put(1'b0, 1'b0, 1'b0, 20'h0_0000);
    endtask

    // Wait state: optional stall with data_valid low, then one cycle with data_valid high.
    task automatic gen_wait(input int w, input int stall_w, input int stall_n, input int bidx);
        logic [19:0] v;
        v = exp_out(0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, bidx, 1'b1, 1'b0);
        if (w == stall_w) begin
            for (int k = 0; k < stall_n; k++) put(1'b0, 1'b0, 1'b0, v);
        end
        put(1'b0, 1'b1, 1'b0, v);
    endtask

    // One full message; data_valid is kept high outside the chosen stall to show it is ignored there.
    task automatic gen_msg(input int pb, input int stall_w, input int stall_n);
        plan_q.delete();
        put(1'b0, 1'b0, 1'b0, 20'h0_0000);
        put(1'b0, 1'b0, 1'b0, 20'h0_0000);
        start_idx = plan_q.size();
        put(1'b1, 1'b0, 1'b0, 20'h0_0000);
        for (int r = 0; r < 12; r++)
            put(1'b0, 1'b1, 1'b0, exp_out(r, (r == 0), 1'b0, 1'b0, (r == 11), 2'b00,
                                          1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0));
        gen_wait(0, stall_w, stall_n, 0);
        for (int r = 6; r < 12; r++)
            put(1'b0, 1'b1, 1'b0, exp_out(r, 1'b0, (r == 6), 1'b0, (r == 11),
                                          (r == 11) ? 2'b01 : 2'b00, 1'b1, 1'b0, 1'b0, (r == 6),
                                          0, 1'b1, 1'b0));
        for (int b = 0; b < pb - 1; b++) begin
            gen_wait(b + 1, stall_w, stall_n, b);
            for (int r = 6; r < 12; r++)
                put(1'b0, 1'b1, 1'b0, exp_out(r, 1'b0, (r == 6), 1'b0, 1'b0, 2'b00, 1'b1,
                                              (r == 6), 1'b0, (r == 6), b, 1'b1, 1'b0));
        end
        gen_wait(pb, stall_w, stall_n, pb - 1);
        for (int r = 0; r < 12; r++)
            put(1'b0, 1'b1, 1'b0, exp_out(r, 1'b0, (r == 0), (r == 0), (r == 11),
                                          (r == 11) ? 2'b10 : 2'b00, 1'b1, (r == 0), 1'b0,
                                          (r == 0), pb - 1, 1'b1, 1'b0));
        put(1'b0, 1'b1, 1'b0, exp_out(0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1,
                                      1'b0, pb - 1, 1'b1, 1'b1));
        for (int k = 0; k < 3; k++) put(1'b0, 1'b0, 1'b0, 20'h0_0000);
    endtask

    // Drive the plan one cycle per negedge; the expected vector for the next cycle is queued as each input is driven.
    task automatic run_plan(input int n_max);
        logic [19:0] exp_v;
        logic [19:0] o_v;
        int          c;
        sb_q.delete();
        done_cyc = 0;
        done_cnt = 0;
        if (plan_q.size() > 0) sb_q.push_back(plan_q[0].out);
        for (int i = 0; i < plan_q.size() && i < n_max; i++) begin
            @(negedge clock_i);
            c   = i - start_idx;
            o_v = obs_vec(sel);
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                check_eq($sformatf("trace_dut%0d_c%0d", sel, c), 32'(o_v), 32'(exp_v));
            end
            if (o_v[0]) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            drive(plan_q[i]);
            if (i + 1 < plan_q.size()) sb_q.push_back(plan_q[i + 1].out);
        end
    endtask

    initial begin
        plan_t p0;
        n_checks  = 0;
        n_fail    = 0;
        sel       = 0;
        start_idx = 0;

        // Reset with start and data_valid asserted on both controllers.
        resetb_i = 1'b0;
        p0.st = 1'b1; p0.dv = 1'b1; p0.ab = 1'b0; p0.out = 20'h0_0000;
        sel = 0; drive(p0);
        bus1.start_i = 1'b1; bus1.data_valid_i = 1'b1;
        repeat (3) @(negedge clock_i);
        check_eq("rst_dut4", 32'(obs_vec(0)), 32'h0);
        check_eq("rst_dut1", 32'(obs_vec(1)), 32'h0);
        p0.st = 1'b0; p0.dv = 1'b0;
        drive(p0);
        resetb_i = 1'b1;
        gen_idle(4);
        run_plan(100);
        check_eq("rst_release_idle_no_done", 32'(done_cnt), 32'd0);

        // Nominal message with a start pulse during plaintext block 0.
        gen_msg(4, -1, 0);
        plan_q[start_idx + 22].st = 1'b1;
        run_plan(1000);
        check_eq("nominal_done_cycle", 32'(done_cyc), 32'd54);
        check_eq("nominal_done_count", 32'(done_cnt), 32'd1);

        // Upstream stalls five cycles in WAIT_PT after block 0.
        gen_msg(4, 2, 5);
        run_plan(1000);
        check_eq("stall_done_cycle", 32'(done_cyc), 32'd59);

        // Single plaintext block controller.
        sel = 1;
        gen_msg(1, -1, 0);
        run_plan(1000);
        check_eq("pb1_done_cycle", 32'(done_cyc), 32'd33);
        sel = 0;

        // Reset pulse during AD at round 8.
        gen_msg(4, -1, 0);
        run_plan(start_idx + 17);
        #2 resetb_i = 1'b0;
        #1 check_eq("rst_mid_outputs", 32'(obs_vec(0)), 32'h0);
        @(negedge clock_i);
        resetb_i = 1'b1;
        gen_idle(6);
        run_plan(100);
        check_eq("rst_mid_no_done", 32'(done_cnt), 32'd0);

`ifdef ASCON_CTRL_ABORT_EN
        // Abort while idle is ignored; abort at INIT round 11 wins over the exit transition.
        gen_msg(4, -1, 0);
        plan_q[0].ab = 1'b1;
        plan_q[start_idx + 12].ab = 1'b1;
        while (plan_q.size() > start_idx + 13) void'(plan_q.pop_back());
        for (int k = 0; k < 4; k++) put(1'b0, 1'b1, 1'b0, 20'h0_0000);
        run_plan(1000);
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        gen_msg(4, -1, 0);
        run_plan(1000);
        check_eq("abort_restart_done_cycle", 32'(done_cyc), 32'd54);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
